pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined CPU (IF, ID, EXE, MEM, WB).
- Decides each cycle whether the PC and pipeline registers advance, hold or flush, and selects the next-PC source.
- Freezes the whole pipeline while a multi-cycle data memory has not acknowledged.
- Keeps saturating stall and flush counters for debug.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.
- MAX_WAIT, 64, number of memory-wait cycles without mem_ack before the error trap.
- WAIT_W, 7, width of the memory-wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- Jump  in  1  the ID instruction is a jump.
- Branch  in  1  a branch in EXE is taken.
- EXE_MemtoReg  in  1  the EXE instruction is a load.
- EXE_RegWr  in  1  the EXE instruction writes a register.
- EXE_Rw  in  5  destination register of the EXE instruction.
- MEM_MemWr  in  1  the MEM instruction is a store.
- MEM_MemtoReg  in  1  the MEM instruction is a load.
- mem_ack  in  1  data memory has completed the current access.
- pc_sel  out  2  next-PC source: 0 = PC+4, 1 = ID_jpc, 2 = EXE_bpc.
- stall_pc  out  1  hold the PC.
- stall_IF_ID  out  1  hold IF/ID.
- flush_IF_ID  out  1  load NOP into IF/ID.
- flush_ID_EXE  out  1  load a bubble into ID/EXE.
- hold_all  out  1  hold ID/EXE, EXE/MEM and MEM/WB.
- err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1.
- flush_cnt  out  CNT_W  saturating count of cycles with flush_IF_ID or flush_ID_EXE.

Behaviour:
- States: RUN, MEM_WAIT, ERR.
- Reset (reset=0, asynchronous): state=RUN, wait_cnt=0, counters=0, err=0.
- Combinational controls are computed from the inputs and state; they are not registered.
- Definitions:
  - mem_req = MEM_MemWr | MEM_MemtoReg.
  - lu = EXE_MemtoReg & EXE_RegWr & (EXE_Rw!=0) & ((EXE_Rw==ID_Rs) | (ID_UsesRt & (EXE_Rw==ID_Rt))).
- Priority in RUN, highest first:
  1. mem_req & !mem_ack: freeze. stall_pc = stall_IF_ID = hold_all = 1, no flushes, pc_sel=0. Next state MEM_WAIT, wait_cnt=1.
  2. Branch: pc_sel=2, flush_IF_ID=1, flush_ID_EXE=1, no stalls. This overrides lu and Jump because the ID instruction is on the wrong path.
  3. lu: stall_pc=1, stall_IF_ID=1, flush_ID_EXE=1, pc_sel=0. Exactly one bubble is inserted; next cycle lu is false because the load has moved to MEM.
  4. Jump: pc_sel=1, flush_IF_ID=1.
  5. Otherwise all controls are 0 and pc_sel=0.
- MEM_WAIT:
  - Full freeze as in item 1 while !mem_ack; wait_cnt increments each cycle.
  - mem_ack=1: same cycle, apply the RUN priority list excluding item 1. Next state RUN, wait_cnt=0.
  - wait_cnt reaches MAX_WAIT with mem_ack=0: next state ERR.
- ERR: full freeze permanently, err=1; left only by reset.
- Branch/Jump arriving during a freeze are ignored; their source registers are held, so they are re-evaluated on release.
- A freeze masks lu. Unless mem_ack is already 1, a freeze delays lu resolution by at least one cycle.
- Counters:
  - stall_cnt increments when stall_pc=1; flush_cnt increments when either flush is 1.
  - Both saturate at all-ones and never wrap.
  - Counting continues in ERR: stall_cnt keeps incrementing until it saturates.
- Asynchronous reset in any state, including mid-wait: immediate return to reset values.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state enum {RUN, MEM_WAIT, ERR};
  - pc_sel constants PC_SEQ=0, PC_JMP=1, PC_BR=2;
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter W, inputs inc and clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: EXE_MemtoReg=1, EXE_RegWr=1, EXE_Rw=8, ID_Rs=8, mem_ack=1 -> one cycle of stall_pc=stall_IF_ID=flush_ID_EXE=1, then all 0; stall_cnt=1.
- $zero and rt masking: EXE_Rw=0, ID_Rs=0 -> no stall. EXE_Rw=9, ID_Rt=9, ID_UsesRt=0 -> no stall; with ID_UsesRt=1 -> stall.
- Branch over load-use and Jump: Branch=1, Jump=1, lu true -> pc_sel=2, flush_IF_ID=flush_ID_EXE=1, stall_pc=0; flush_cnt=1.
- Memory wait: MEM_MemtoReg=1, mem_ack held 0 for 3 cycles then 1 -> hold_all=1 for 3 cycles, state returns to RUN after the ack cycle; stall_cnt=3.
- Timeout: MAX_WAIT=4, mem_ack stuck 0 -> err=1 after 4 wait cycles and stays 1; reset=0 clears err and the counters asynchronously.
- Saturation: CNT_W=4, lu held active for 20 cycles via toggling stimulus -> stall_cnt stops at 15.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline control logic of the 5-stage CPU.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_JMP = 2'd1;
    localparam logic [1:0] PC_BR  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch/jump flushes, next-PC
// select, and a whole-pipeline freeze while data memory has not acknowledged.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             EXE_MemtoReg,
    input  logic             EXE_RegWr,
    input  logic [4:0]       EXE_Rw,
    input  logic             MEM_MemWr,
    input  logic             MEM_MemtoReg,
    input  logic             mem_ack,
    output logic [1:0]       pc_sel,
    output logic             stall_pc,
    output logic             stall_IF_ID,
    output logic             flush_IF_ID,
    output logic             flush_ID_EXE,
    output logic             hold_all,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              mem_req, lu, freeze, resolve;

    assign mem_req = MEM_MemWr | MEM_MemtoReg;
    assign lu = EXE_MemtoReg & EXE_RegWr & (EXE_Rw != REG_ZERO) &
                ((EXE_Rw == ID_Rs) | (ID_UsesRt & (EXE_Rw == ID_Rt)));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Sequencing: decide whether this cycle freezes or resolves hazards.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        freeze    = 1'b0;
        resolve   = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    freeze    = 1'b1;
                    wait_nxt  = WAIT_W'(1);
                    state_nxt = (MAX_WAIT <= 1) ? ERR : MEM_WAIT;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    resolve   = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + 1'b1;
                    if (wait_nxt >= WAIT_W'(MAX_WAIT))
                        state_nxt = ERR;
                end
            end
            ERR: freeze = 1'b1;
            default: begin
                freeze    = 1'b1;
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Branch outranks load-use and jump: the ID instruction is on the wrong path.
    always_comb begin
        pc_sel       = PC_SEQ;
        stall_pc     = 1'b0;
        stall_IF_ID  = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EXE = 1'b0;
        hold_all     = 1'b0;
        if (freeze) begin
            stall_pc    = 1'b1;
            stall_IF_ID = 1'b1;
            hold_all    = 1'b1;
        end else if (resolve) begin
            if (Branch) begin
                pc_sel       = PC_BR;
                flush_IF_ID  = 1'b1;
                flush_ID_EXE = 1'b1;
            end else if (lu) begin
                stall_pc     = 1'b1;
                stall_IF_ID  = 1'b1;
                flush_ID_EXE = 1'b1;
            end else if (Jump) begin
                pc_sel      = PC_JMP;
                flush_IF_ID = 1'b1;
            end
        end
    end

    assign err = (state == ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .inc   (stall_pc),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (reset),
        .inc   (flush_IF_ID | flush_ID_EXE),
        .clear (1'b0),
        .cnt   (flush_cnt)
    );

endmodule
